// File: rtl/vsync_std_lock_ctrl.sv
// rtl/vsync_std_lock_ctrl.sv - VSYNC period measurement and PAL/NTSC lock controller
// Frames are timed in prescaler ticks; the reported standard moves only through acquire/lock hysteresis.
module vsync_std_lock_ctrl #(
  parameter int CNT_W         = 6,
  parameter int PAL_MIN       = 24,
  parameter int MIN_VALID     = 16,
  parameter int MAX_VALID     = 31,
  parameter int TIMEOUT       = 48,
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_FRAMES = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick,
  input  logic             vsync_in,
  output logic             is_pal,
  output logic             is_ntsc,
  output logic             locked,
  output logic             no_signal,
  output logic             std_changed,
  output logic             frame_strobe,
  output logic [CNT_W-1:0] period_out
);

  localparam int AGR_W = $clog2(LOCK_FRAMES + 1);
  localparam int MIS_W = $clog2(UNLOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] P_MIN     = CNT_W'(MIN_VALID);
  localparam logic [CNT_W-1:0] P_MAX     = CNT_W'(MAX_VALID);
  localparam logic [CNT_W-1:0] P_PAL     = CNT_W'(PAL_MIN);
  localparam logic [AGR_W-1:0] AGR_ZERO  = '0;
  localparam logic [AGR_W-1:0] AGR_ONE   = AGR_W'(1);
  localparam logic [AGR_W-1:0] AGR_LOCK  = AGR_W'(LOCK_FRAMES);
  localparam logic [MIS_W-1:0] MIS_ZERO  = '0;
  localparam logic [MIS_W-1:0] MIS_ONE   = MIS_W'(1);
  localparam logic [MIS_W-1:0] MIS_LIMIT = MIS_W'(UNLOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_NO_SIGNAL = 2'd0,
    ST_SEARCH    = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             sync1, sync2, sync_prev;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic             valid, cls, timed_out;
  logic [AGR_W-1:0] agree, agree_next, agree_inc, agree_sum;
  logic [MIS_W-1:0] miss, miss_next, miss_inc;
  logic             cand, cand_next;
  logic             pal_next, chg_next;

  // Synchronisers reset low so a high VSYNC at reset release cannot fake a falling edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= vsync_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign fall = sync_prev & ~sync2;

  // A tick landing on the edge cycle belongs to the next frame.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= CNT_ZERO;
    end else if (fall) begin
      cnt <= tick ? CNT_ONE : CNT_ZERO;
    end else if (tick && (cnt < CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign valid     = (cnt >= P_MIN) && (cnt <= P_MAX);
  assign cls       = (cnt >= P_PAL);
  assign timed_out = (cnt == CNT_MAX);
  assign agree_inc = (agree == AGR_LOCK) ? agree : agree + AGR_ONE;
  assign miss_inc  = miss + MIS_ONE;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= ST_NO_SIGNAL;
      agree <= AGR_ZERO;
      miss  <= MIS_ZERO;
      cand  <= 1'b0;
    end else begin
      state <= state_next;
      agree <= agree_next;
      miss  <= miss_next;
      cand  <= cand_next;
    end
  end

  always_comb begin
    state_next = state;
    agree_next = agree;
    agree_sum  = agree;
    miss_next  = miss;
    cand_next  = cand;
    pal_next   = is_pal;
    chg_next   = 1'b0;
    case (state)
      ST_NO_SIGNAL: begin
        if (fall) begin
          state_next = ST_SEARCH;
          agree_next = AGR_ZERO;
          cand_next  = 1'b0;
          miss_next  = MIS_ZERO;
        end
      end
      ST_SEARCH: begin
        if (fall) begin
          if (!valid) begin
            agree_next = AGR_ZERO;
          end else begin
            if (cls == cand) begin
              agree_sum = agree_inc;
            end else begin
              cand_next = cls;
              agree_sum = AGR_ONE;
            end
            agree_next = agree_sum;
            if (agree_sum >= AGR_LOCK) begin
              state_next = ST_LOCKED;
              pal_next   = cand_next;
              miss_next  = MIS_ZERO;
              chg_next   = (cand_next != is_pal);
            end
          end
        end else if (timed_out) begin
          state_next = ST_NO_SIGNAL;
        end
      end
      ST_LOCKED: begin
        if (fall) begin
          if (valid && (cls == is_pal)) begin
            miss_next = MIS_ZERO;
          end else if (miss_inc >= MIS_LIMIT) begin
            state_next = ST_SEARCH;
            agree_next = AGR_ZERO;
            cand_next  = is_pal;
            miss_next  = MIS_ZERO;
          end else begin
            miss_next = miss_inc;
          end
        end else if (timed_out) begin
          state_next = ST_NO_SIGNAL;
        end
      end
      default: begin
        state_next = ST_NO_SIGNAL;
      end
    endcase
  end

  // Status flags follow the next state so they line up with the edge that caused them.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      is_pal       <= 1'b0;
      is_ntsc      <= 1'b1;
      locked       <= 1'b0;
      no_signal    <= 1'b1;
      std_changed  <= 1'b0;
      frame_strobe <= 1'b0;
      period_out   <= CNT_ZERO;
    end else begin
      is_pal       <= pal_next;
      is_ntsc      <= ~pal_next;
      locked       <= (state_next == ST_LOCKED);
      no_signal    <= (state_next == ST_NO_SIGNAL);
      std_changed  <= chg_next;
      frame_strobe <= fall;
      if (fall) begin
        period_out <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_vsync_std_lock_ctrl.sv
// tb/tb_vsync_std_lock_ctrl.sv - self-checking bench for vsync_std_lock_ctrl
// Frame-level reference model driven by directed and random tick/VSYNC sequences.
module tb_vsync_std_lock_ctrl;

  logic       clk_in, rst, tick, vsync_in;
  logic       is_pal, is_ntsc, locked, no_signal, std_changed, frame_strobe;
  logic [5:0] period_out;

  vsync_std_lock_ctrl dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .tick         (tick),
    .vsync_in     (vsync_in),
    .is_pal       (is_pal),
    .is_ntsc      (is_ntsc),
    .locked       (locked),
    .no_signal    (no_signal),
    .std_changed  (std_changed),
    .frame_strobe (frame_strobe),
    .period_out   (period_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  int chg_cnt = 0;

  // model state: 0 no signal, 1 searching, 2 locked
  int m_state, m_agree, m_miss, m_period, ticks_since_edge;
  bit m_cand, m_pal, m_chg;

  logic [11:0] obs, exp_v;
  logic [1:0]  obs_after;

  always @(negedge clk_in) if (std_changed === 1'b1) chg_cnt++;

  function automatic logic [11:0] model_vec();
    return {m_state == 2, m_state == 0, m_pal, !m_pal, m_chg, 1'b1, 6'(m_period)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_agree = 0; m_miss = 0; m_cand = 0; m_pal = 0; m_chg = 0;
    m_period = 0; ticks_since_edge = 0;
  endtask

  task automatic model_edge(input bit coinc);
    int  p;
    bit  valid, cls;
    if (ticks_since_edge >= 48 && m_state != 0) m_state = 0;
    p = (ticks_since_edge > 48) ? 48 : ticks_since_edge;
    m_period = p;
    m_chg = 0;
    valid = (p >= 16) && (p <= 31);
    cls = (p >= 24);
    case (m_state)
      0: begin m_state = 1; m_agree = 0; m_cand = 0; m_miss = 0; end
      1: begin
        if (!valid) m_agree = 0;
        else begin
          if (cls == m_cand) begin if (m_agree < 4) m_agree++; end
          else begin m_cand = cls; m_agree = 1; end
          if (m_agree >= 4) begin
            m_state = 2; m_chg = (m_cand != m_pal); m_pal = m_cand; m_miss = 0;
          end
        end
      end
      default: begin
        if (valid && cls == m_pal) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == 3) begin m_state = 1; m_agree = 0; m_cand = m_pal; end
        end
      end
    endcase
    ticks_since_edge = coinc ? 1 : 0;
  endtask

  task automatic do_tick();
    @(negedge clk_in) tick = 1'b1;
    @(negedge clk_in) tick = 1'b0;
    ticks_since_edge++;
  endtask

  // n ticks, then a VSYNC fall; coinc places a tick on the DUT's edge cycle
  task automatic frame(input int n, input bit coinc);
    repeat (n) do_tick();
    @(negedge clk_in) vsync_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in) tick = coinc;
    @(negedge clk_in) tick = 1'b0;
    obs = {locked, no_signal, is_pal, is_ntsc, std_changed, frame_strobe, period_out};
    model_edge(coinc);
    exp_v = model_vec();
    @(negedge clk_in) obs_after = {std_changed, frame_strobe};
    vsync_in = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic reset_dut();
    @(negedge clk_in) rst = 1'b1;
    @(negedge clk_in) rst = 1'b0;
    model_reset();
  endtask

  task automatic acquire_pal();
    reset_dut();
    repeat (5) frame(25, 1'b0);
  endtask

  task automatic test_reset();
    logic [11:0] v;
    repeat (2) @(negedge clk_in);
    v = {locked, no_signal, is_pal, is_ntsc, std_changed, frame_strobe, period_out};
    n_cmp++;
    if (v !== 12'b0101_0000_0000) begin
      n_err++; $display("FAIL reset_values got=%b want=%b", v, 12'b0101_0000_0000);
    end
    @(negedge clk_in) rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pal_acquire();
    int c0;
    c0 = chg_cnt;
    for (int i = 1; i <= 5; i++) begin
      frame(25, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL acquire_frame%0d got=%b want=%b", i, obs, exp_v); end
      if (i == 1) begin
        n_cmp++;
        if (obs[10] !== 1'b0) begin n_err++; $display("FAIL first_edge_no_signal got=%b want=0", obs[10]); end
      end
    end
    n_cmp++;
    if ({obs[11], obs[9], obs[7], obs[5:0]} !== {3'b111, 6'd25}) begin
      n_err++; $display("FAIL pal_lock got=%b want=%b", {obs[11], obs[9], obs[7], obs[5:0]}, {3'b111, 6'd25});
    end
    n_cmp++;
    if (obs_after !== 2'b00 || chg_cnt - c0 != 1) begin
      n_err++; $display("FAIL pal_chg_single got after=%b pulses=%0d want after=00 pulses=1", obs_after, chg_cnt - c0);
    end
  endtask

  task automatic test_ntsc_switch();
    for (int i = 1; i <= 7; i++) begin
      frame(21, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL ntsc_frame%0d got=%b want=%b", i, obs, exp_v); end
      if (i == 3) begin
        n_cmp++;
        if ({obs[11], obs[9]} !== 2'b01) begin n_err++; $display("FAIL unlock_hold got=%b want=01", {obs[11], obs[9]}); end
      end
    end
    n_cmp++;
    if ({obs[11], obs[8], obs[7]} !== 3'b111) begin
      n_err++; $display("FAIL ntsc_lock got=%b want=111", {obs[11], obs[8], obs[7]});
    end
  endtask

  task automatic test_glitch();
    int c0;
    acquire_pal();
    c0 = chg_cnt;
    frame(10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== exp_v || obs[11] !== 1'b1) begin n_err++; $display("FAIL glitch_frame%0d got=%b want=%b", i, obs, exp_v); end
      frame(25, 1'b0);
    end
    n_cmp++;
    if (chg_cnt != c0) begin n_err++; $display("FAIL glitch_no_change got=%0d want=0", chg_cnt - c0); end
  endtask

  task automatic test_timeout();
    acquire_pal();
    repeat (47) do_tick();
    @(negedge clk_in);
    n_cmp++;
    if ({no_signal, locked} !== 2'b01) begin n_err++; $display("FAIL timeout_early got=%b want=01", {no_signal, locked}); end
    do_tick();
    @(negedge clk_in);
    n_cmp++;
    if ({no_signal, locked, is_pal} !== 3'b101) begin
      n_err++; $display("FAIL timeout got=%b want=101", {no_signal, locked, is_pal});
    end
    frame(25, 1'b0);
    n_cmp++;
    if (obs !== exp_v || obs[5:0] !== 6'd48) begin n_err++; $display("FAIL timeout_recover got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_coincident();
    reset_dut();
    frame(20, 1'b0);
    frame(20, 1'b1);
    n_cmp++;
    if (obs[5:0] !== 6'd20 || obs !== exp_v) begin n_err++; $display("FAIL coinc_excl got=%b want=%b", obs, exp_v); end
    frame(20, 1'b0);
    n_cmp++;
    if (obs[5:0] !== 6'd21 || obs !== exp_v) begin n_err++; $display("FAIL coinc_next got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_reset_mid_lock();
    logic [11:0] v;
    acquire_pal();
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1 v = {locked, no_signal, is_pal, is_ntsc, std_changed, frame_strobe, period_out};
    n_cmp++;
    if (v !== 12'b0101_0000_0000) begin n_err++; $display("FAIL async_reset got=%b want=%b", v, 12'b0101_0000_0000); end
    @(negedge clk_in) rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int n, k;
    bit c;
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7) n = $urandom_range(14, 33);
      else if (k < 9) n = $urandom_range(4, 13);
      else n = $urandom_range(45, 52);
      c = ($urandom_range(0, 3) == 0);
      frame(n, c);
      n_cmp++;
      if (obs !== exp_v || obs_after !== 2'b00) begin
        n_err++; $display("FAIL random_frame%0d n=%0d got=%b/%b want=%b/00", i, n, obs, obs_after, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    vsync_in = 1'b1;
    model_reset();
    test_reset();
    test_pal_acquire();
    test_ntsc_switch();
    test_glitch();
    test_timeout();
    test_coincident();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
